// File: rtl/lsu_req_ctrl.sv
// lsu_req_ctrl: memory-access stage; checks alignment and range, issues a one-cycle access,
// and returns the registered load result over a valid/ready handshake.
`timescale 1ns/1ps
module lsu_req_ctrl #(
   parameter int ADDR_W      = 8,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic        i_req_load,
   input  logic        i_req_store,
   input  logic [1:0]  i_req_dw,
   input  logic        i_req_sign,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_fault,
   output logic [3:0]  o_resp_cause,
   output logic        o_mem_en,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic        o_mem_l,
   output logic        o_mem_s,
   output logic        o_mem_sign,
   output logic [1:0]  o_mem_dw,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_cnt_load,
   output logic [31:0] o_cnt_store,
   output logic [31:0] o_cnt_fault
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

   state_t      r_state, w_state_nxt;
   logic        r_mem_en, r_mem_l, r_mem_s, r_mem_sign;
   logic [31:0] r_mem_addr, r_mem_wdata;
   logic [1:0]  r_mem_dw;
   logic [31:0] r_resp_rdata;
   logic        r_resp_fault;
   logic [3:0]  r_resp_cause;
   logic [31:0] r_cnt_load, r_cnt_store, r_cnt_fault;
   logic        w_accept, w_range_err, w_misalign, w_fault, w_legal;
   logic [32:0] w_size;
   logic [3:0]  w_cause;

   assign o_req_ready  = rst_n && (r_state == IDLE);
   assign o_resp_valid = (r_state == RESP);
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_fault = r_resp_fault;
   assign o_resp_cause = r_resp_cause;
   assign o_mem_en     = r_mem_en;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_mem_l      = r_mem_l;
   assign o_mem_s      = r_mem_s;
   assign o_mem_sign   = r_mem_sign;
   assign o_mem_dw     = r_mem_dw;
   assign o_cnt_load   = r_cnt_load;
   assign o_cnt_store  = r_cnt_store;
   assign o_cnt_fault  = r_cnt_fault;

   // 33-bit end address so a request wrapping past 2**32 is still out of range
   always_comb begin
      w_accept    = i_req_valid && o_req_ready;
      w_size      = (i_req_dw == 2'd0) ? 33'd1 : (i_req_dw == 2'd1) ? 33'd2 : 33'd4;
      w_range_err = ({1'b0, i_req_addr} + w_size) > DEPTH;
      w_misalign  = ALIGN_CHECK && (((i_req_dw == 2'd1) && i_req_addr[0]) ||
                                    ((i_req_dw == 2'd2) && (i_req_addr[1:0] != 2'b00)));
      w_cause     = (i_req_load && i_req_store)             ? 4'd7 :
                    ((i_req_dw == 2'd3) || w_range_err)     ? (i_req_store ? 4'd7 : 4'd5) :
                    w_misalign                              ? (i_req_store ? 4'd6 : 4'd4) : 4'd0;
      w_fault     = (w_cause != 4'd0);
      w_legal     = !w_fault && (i_req_load || i_req_store);
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = w_accept ? (w_legal ? ACCESS : RESP) : IDLE;
         ACCESS:  w_state_nxt = RESP;
         RESP:    w_state_nxt = i_resp_ready ? IDLE : RESP;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_mem_en     <= 1'b0;
         r_mem_l      <= 1'b0;
         r_mem_s      <= 1'b0;
         r_mem_sign   <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_dw     <= '0;
         r_resp_rdata <= '0;
         r_resp_fault <= 1'b0;
         r_resp_cause <= '0;
         r_cnt_load   <= '0;
         r_cnt_store  <= '0;
         r_cnt_fault  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_accept) begin
            if (w_legal) begin
               r_mem_en    <= 1'b1;
               r_mem_l     <= i_req_load;
               r_mem_s     <= i_req_store;
               r_mem_sign  <= i_req_sign;
               r_mem_addr  <= i_req_addr;
               r_mem_wdata <= i_req_wdata;
               r_mem_dw    <= i_req_dw;
            end else begin
               r_resp_rdata <= '0;
               r_resp_fault <= w_fault;
               r_resp_cause <= w_cause;
               r_cnt_fault  <= r_cnt_fault + 32'(w_fault);
            end
         end else if (r_state == ACCESS) begin
            r_mem_en     <= 1'b0;
            r_mem_l      <= 1'b0;
            r_mem_s      <= 1'b0;
            r_resp_rdata <= r_mem_l ? i_mem_rdata : 32'd0;
            r_resp_fault <= 1'b0;
            r_resp_cause <= '0;
            r_cnt_load   <= r_cnt_load + 32'(r_mem_l);
            r_cnt_store  <= r_cnt_store + 32'(r_mem_s);
         end else if (r_state == RESP && i_resp_ready) begin
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
            r_resp_cause <= '0;
         end
      end
   end
endmodule

// File: tb/tb_lsu_req_ctrl.sv
// tb_lsu_req_ctrl: scoreboard bench with a byte-array data memory model behind the DUT.
`timescale 1ns/1ps
module tb_lsu_req_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, v0 = 1'b0, req_load = 1'b0, req_store = 1'b0, req_sign = 1'b0;
   logic        resp_ready = 1'b1;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_dw = '0;
   logic        req_ready, resp_valid, resp_fault, mem_en, mem_l, mem_s, mem_sign;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata, cnt_load, cnt_store, cnt_fault;
   logic [3:0]  resp_cause;
   logic [1:0]  mem_dw;
   logic        o0_req_ready, o0_resp_valid, o0_resp_fault, o0_mem_en, o0_mem_l, o0_mem_s, o0_mem_sign;
   logic [31:0] o0_resp_rdata, o0_mem_addr, o0_mem_wdata, o0_mem_rdata, o0_cnt_l, o0_cnt_s, o0_cnt_f;
   logic [3:0]  o0_resp_cause;
   logic [1:0]  o0_mem_dw;
   logic [7:0]  mem [256];
   logic [7:0]  wa;
   int          n_cmp = 0, n_err = 0;

   typedef struct {logic [31:0] rdata; logic [3:0] cause; int lat;} exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   lsu_req_ctrl #(.ADDR_W(8), .ALIGN_CHECK(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_load(req_load), .i_req_store(req_store),
      .i_req_dw(req_dw), .i_req_sign(req_sign), .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
      .o_resp_rdata(resp_rdata), .o_resp_fault(resp_fault), .o_resp_cause(resp_cause),
      .o_mem_en(mem_en), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_l(mem_l),
      .o_mem_s(mem_s), .o_mem_sign(mem_sign), .o_mem_dw(mem_dw), .i_mem_rdata(mem_rdata),
      .o_cnt_load(cnt_load), .o_cnt_store(cnt_store), .o_cnt_fault(cnt_fault));

   lsu_req_ctrl #(.ADDR_W(8), .ALIGN_CHECK(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_req_valid(v0), .o_req_ready(o0_req_ready),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_load(req_load), .i_req_store(req_store),
      .i_req_dw(req_dw), .i_req_sign(req_sign), .o_resp_valid(o0_resp_valid), .i_resp_ready(resp_ready),
      .o_resp_rdata(o0_resp_rdata), .o_resp_fault(o0_resp_fault), .o_resp_cause(o0_resp_cause),
      .o_mem_en(o0_mem_en), .o_mem_addr(o0_mem_addr), .o_mem_wdata(o0_mem_wdata), .o_mem_l(o0_mem_l),
      .o_mem_s(o0_mem_s), .o_mem_sign(o0_mem_sign), .o_mem_dw(o0_mem_dw), .i_mem_rdata(o0_mem_rdata),
      .o_cnt_load(o0_cnt_l), .o_cnt_store(o0_cnt_s), .o_cnt_fault(o0_cnt_f));

   function automatic logic [31:0] ext(input logic [31:0] r, input logic [1:0] dw, input logic s);
      return (dw == 2'd0) ? {{24{s & r[7]}}, r[7:0]} : (dw == 2'd1) ? {{16{s & r[15]}}, r[15:0]} : r;
   endfunction

   always_comb begin
      mem_rdata    = ext({mem[8'(mem_addr[7:0] + 8'd3)], mem[8'(mem_addr[7:0] + 8'd2)],
                          mem[8'(mem_addr[7:0] + 8'd1)], mem[mem_addr[7:0]]}, mem_dw, mem_sign);
      o0_mem_rdata = ext({mem[8'(o0_mem_addr[7:0] + 8'd3)], mem[8'(o0_mem_addr[7:0] + 8'd2)],
                          mem[8'(o0_mem_addr[7:0] + 8'd1)], mem[o0_mem_addr[7:0]]}, o0_mem_dw, o0_mem_sign);
   end

   // stores land at the negedge inside ACCESS
   assign wa = mem_addr[7:0];
   always @(negedge clk) begin
      if (mem_en && mem_s) begin
         mem[wa] <= mem_wdata[7:0];
         if (mem_dw != 2'd0) mem[8'(wa + 8'd1)] <= mem_wdata[15:8];
         if (mem_dw == 2'd2) begin
            mem[8'(wa + 8'd2)] <= mem_wdata[23:16];
            mem[8'(wa + 8'd3)] <= mem_wdata[31:24];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic ld, input logic st,
                       input logic [1:0] dw, input logic sg, input logic [31:0] er, input logic [3:0] ec);
      exp_t e;
      int   k = 0;
      @(negedge clk);
      req_addr = a; req_wdata = wd; req_load = ld; req_store = st; req_dw = dw; req_sign = sg;
      req_valid = 1'b1;
      e.rdata = er; e.cause = ec; e.lat = (ec == 4'd0 && (ld || st)) ? 1 : 0;
      q.push_back(e);
      while (!req_ready && k < 10) begin k++; @(negedge clk); end
      chk("accept_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic get(input int hold);
      exp_t e;
      int   lat = 0, en = 0;
      resp_ready = (hold == 0);
      @(negedge clk);
      while (!resp_valid && lat < 8) begin en += int'(mem_en); lat++; @(negedge clk); end
      chk("sb_depth", 32'(q.size()), 32'd1);
      if (q.size() == 0) return;
      e = q.pop_front();
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("latency", 32'(lat), 32'(e.lat));
      chk("mem_en_cycles", 32'(en), 32'(e.lat));
      chk("rdata", resp_rdata, e.rdata);
      chk("fault", 32'(resp_fault), 32'(e.cause != 4'd0));
      chk("cause", 32'(resp_cause), 32'(e.cause));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_rdata", resp_rdata, e.rdata);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_resp_valid", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_cnt_store", cnt_store, 32'd0);
      rst_n = 1'b1;
      send(32'h10, 32'hDEADBEEF, 0, 1, 2'd2, 0, 32'h0, 4'd0); get(0);
      chk("cnt_store_1", cnt_store, 32'd1);
      send(32'h10, 32'h0, 1, 0, 2'd2, 0, 32'hDEADBEEF, 4'd0); get(0);
      chk("cnt_load_1", cnt_load, 32'd1);
      send(32'h13, 32'h80, 0, 1, 2'd0, 0, 32'h0, 4'd0); get(0);
      send(32'h13, 32'h0, 1, 0, 2'd0, 1, 32'hFFFFFF80, 4'd0); get(0);
      send(32'h13, 32'h0, 1, 0, 2'd0, 0, 32'h00000080, 4'd0); get(0);
      send(32'h12, 32'h0, 1, 0, 2'd1, 1, 32'hFFFF80AD, 4'd0); get(0);
      send(32'h20, 32'h44332211, 0, 1, 2'd2, 0, 32'h0, 4'd0); get(0);
      send(32'h24, 32'h88776655, 0, 1, 2'd2, 0, 32'h0, 4'd0); get(0);
      send(32'h22, 32'h0, 1, 0, 2'd2, 0, 32'h0, 4'd4); get(0);
      chk("cnt_fault_1", cnt_fault, 32'd1);
      send(32'hFF, 32'h1234, 0, 1, 2'd1, 0, 32'h0, 4'd7); get(0);
      send(32'hFFFFFFFE, 32'h0, 1, 0, 2'd2, 0, 32'h0, 4'd5); get(0);
      send(32'hFC, 32'h11223344, 0, 1, 2'd2, 0, 32'h0, 4'd0); get(0);
      send(32'hFC, 32'h0, 1, 0, 2'd2, 0, 32'h11223344, 4'd0); get(0);
      send(32'h11, 32'h0, 0, 1, 2'd1, 0, 32'h0, 4'd6); get(0);
      send(32'h10, 32'h0, 1, 1, 2'd2, 0, 32'h0, 4'd7); get(0);
      send(32'h10, 32'h0, 1, 0, 2'd3, 0, 32'h0, 4'd5); get(0);
      send(32'h10, 32'h0, 0, 0, 2'd2, 0, 32'h0, 4'd0); get(0);
      chk("cnt_fault_6", cnt_fault, 32'd6);
      send(32'h10, 32'h0, 1, 0, 2'd2, 0, 32'h80ADBEEF, 4'd0); get(5);
      chk("cnt_load_6", cnt_load, 32'd6);
      chk("cnt_store_5", cnt_store, 32'd5);
      @(negedge clk);
      req_addr = 32'h22; req_load = 1'b1; req_store = 1'b0; req_dw = 2'd2; req_sign = 1'b0; v0 = 1'b1;
      @(posedge clk);
      #1 v0 = 1'b0;
      @(negedge clk);
      chk("noalign_mem_en", 32'(o0_mem_en), 32'd1);
      chk("noalign_early_valid", 32'(o0_resp_valid), 32'd0);
      @(negedge clk);
      chk("noalign_valid", 32'(o0_resp_valid), 32'd1);
      chk("noalign_fault", 32'(o0_resp_fault), 32'd0);
      chk("noalign_rdata", o0_resp_rdata, 32'h66554433);
      send(32'h10, 32'h12345678, 0, 1, 2'd2, 0, 32'h0, 4'd0);
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("midrst_mem_en", 32'(mem_en), 32'd0);
      chk("midrst_mem_s", 32'(mem_s), 32'd0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      chk("midrst_cnt_store", cnt_store, 32'd0);
      chk("midrst_cnt_load", cnt_load, 32'd0);
      chk("midrst_cnt_fault", cnt_fault, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("postrst_req_ready", 32'(req_ready), 32'd1);
      send(32'h10, 32'h0, 1, 0, 2'd2, 0, 32'h80ADBEEF, 4'd0); get(0);
      chk("postrst_cnt_load", cnt_load, 32'd1);
      chk("postrst_cnt_store", cnt_store, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/lsu_req_ctrl.md
Name: lsu_req_ctrl

Overview:
- Memory-access stage sitting directly upstream of the data memory (data_src).
- Accepts one load/store request from execute over a valid/ready handshake and checks alignment and address range.
- Drives a single-cycle memory access, registers the load result, and returns it to writeback over a valid/ready handshake.
- Keeps load, store and fault event counters.

Parameters:
- ADDR_W, 8, byte-address width of the backing memory; DEPTH = 2**ADDR_W bytes.
- ALIGN_CHECK, 1, 1 = misaligned halfword/word accesses fault; 0 = passed through unchanged.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  block accepts the request this cycle.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_load  in  1  load request.
- req_store  in  1  store request.
- req_dw  in  2  width: 0 = DB, 1 = DH, 2 = DW, 3 = reserved.
- req_sign  in  1  sign-extend the load result.
- resp_valid  out  1  response available to writeback.
- resp_ready  in  1  writeback consumes the response.
- resp_rdata  out  32  load data; 0 for stores, faults and no-ops.
- resp_fault  out  1  request faulted.
- resp_cause  out  4  RISC-V mcause code: 4 = load misaligned, 5 = load access fault, 6 = store misaligned, 7 = store access fault; 0 when no fault.
- mem_en  out  1  memory enable.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_l, mem_s, mem_sign  out  1 each  packed with mem_dw into control_signals_t at integration.
- mem_dw  out  2  width field for control_signals_t.
- mem_rdata  in  32  combinational, already masked and sign-extended read data.
- cnt_load, cnt_store, cnt_fault  out  32 each  event counters.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (rst_n low, asynchronous):
  - state = IDLE; all registers cleared.
  - req_ready = 0 while rst_n is low; resp_valid = 0, resp_* = 0.
  - mem_en = mem_l = mem_s = mem_sign = 0; mem_dw = 0; mem_addr = mem_wdata = 0.
  - All counters = 0.
- req_ready = 1 only in IDLE with rst_n high. Acceptance = req_valid & req_ready at a posedge; all req_* fields are captured then.
- Classification at acceptance (first match wins):
  - req_store & req_load both set -> store access fault (7).
  - req_dw == 3 -> access fault (5 load / 7 store).
  - addr + size > DEPTH, computed with 33-bit arithmetic so wrap past 2**32 also faults -> access fault (5 / 7). Size is 1 / 2 / 4.
  - ALIGN_CHECK & DH & addr[0] -> misaligned (4 / 6).
  - ALIGN_CHECK & DW & addr[1:0] != 0 -> misaligned (4 / 6).
  - Neither req_load nor req_store set -> no-op.
  - Otherwise -> legal access.
- Legal access:
  - IDLE -> ACCESS.
  - In ACCESS, mem_en = 1 and mem_addr / mem_wdata / mem_dw / mem_sign come from the captured registers. mem_l = load, mem_s = store. These outputs are registered, so they are glitch-free for the whole cycle.
  - Memory performs the store at the negedge inside ACCESS.
  - At the ACCESS-end posedge: resp_rdata <= mem_rdata for loads, 0 for stores; counter increments; -> RESP.
- Faults and no-ops: IDLE -> RESP directly with resp_rdata = 0. Faults set resp_fault and resp_cause and increment cnt_fault. No memory access is issued (mem_en stays 0).
- Latency from the accept edge N:
  - resp_valid rises after edge N+1 for legal accesses.
  - resp_valid rises after edge N for faults and no-ops.
- RESP:
  - resp_valid = 1 and resp_* are held stable until resp_valid & resp_ready at a posedge, then -> IDLE.
  - req_ready is 0 in RESP, so there is no overlap; throughput is one request per 2 cycles (fault / no-op) or 3 cycles (access) with resp_ready held high.
- Counters wrap from 0xFFFFFFFF to 0 with no saturation.
- Reset asserted mid-ACCESS: mem_en and mem_s drop immediately. If reset occurs before the negedge, the store is not performed. The response and counter increment are lost.
- resp_ready high while in IDLE or ACCESS has no effect.
- req_* changing while req_ready = 0 has no effect.

Test Plan:
- Word store then load: store addr 0x10, wdata 0xDEADBEEF, DW. -> mem_en and mem_s high for exactly 1 cycle, then resp_valid with fault 0 and cnt_store = 1. Load DW from 0x10 -> resp_rdata = 0xDEADBEEF, cnt_load = 1.
- Signed byte load: memory byte 0x13 = 0x80; load DB from 0x13, req_sign = 1 -> resp_rdata = 0xFFFFFF80. Same with req_sign = 0 -> 0x00000080.
- Misaligned: ALIGN_CHECK = 1, load DW from 0x22 -> resp after 1 cycle with fault 1, cause 4, mem_en never high, cnt_fault = 1. With ALIGN_CHECK = 0 the same request completes with fault 0.
- Range: store DH to 0xFF (ADDR_W = 8) -> cause 7. Load DW from 0xFFFFFFFE -> cause 5. Load DW from 0xFC -> success.
- Backpressure: complete a load with resp_ready held low for 5 cycles -> resp_valid and resp_rdata stable throughout, req_ready = 0; state returns to IDLE on the cycle after resp_ready rises.
- Reset mid-store: drop rst_n during ACCESS before the negedge -> mem_en = 0 immediately, target memory word unchanged, resp_valid = 0, all counters = 0, req_ready = 1 one cycle after rst_n rises.
